// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - segment patterns and hex decode helper for the scanned display
package seg_display_pkg;

  // Active-low patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Full 8-bit pattern with dp and every segment dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// rtl/seg_display_scan_if.sv - display data in / anode and segment pins out
interface seg_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic                    adj;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;

  modport master (
    output digits, dp_en, adj, blink_mask,
    input  an, seg
  );

  modport slave (
    input  digits, dp_en, adj, blink_mask,
    output an, seg
  );
endinterface

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational hex digit to active-low 7-segment pattern
module seg_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - multiplexed seven-segment scanner with blink; optional SEG_DISPLAY_LEADING_ZERO_BLANK_EN
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 150000,
  parameter int BLINK_DIV   = 12500000
) (
  input logic               clk,
  input logic               rst,
  seg_display_scan_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_mask;
  logic                  cur_lz;
  logic [6:0]            cur_seg7;
  logic [NUM_DIGITS-1:0] lz_blank;

  // Refresh divider: hold each digit for REFRESH_DIV cycles, then step the scan index
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + REF_W'(1);
    scan_idx_d    = scan_idx_q;
    if (refresh_cnt_q == REF_LAST) begin
      refresh_cnt_d = '0;
      scan_idx_d    = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  // Blink divider: frozen at zero outside adjust mode so entry always starts visible
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLK_W'(1);
    blink_phase_d = blink_phase_q;
    if (!bus.adj) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
  // Leading-zero suppression: walk down from the top digit while the run of zeros holds
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (bus.digits[4*i +: 4] == 4'h0);
      if (i > 0) begin
        lz_blank[i] = zero_run & ~bus.dp_en[i];
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Select the digit, dp, blink and suppression bits for the slot being scanned
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_mask  = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_digit = bus.digits[4*i +: 4];
        cur_dp    = bus.dp_en[i];
        cur_mask  = bus.blink_mask[i];
        cur_lz    = lz_blank[i];
      end
    end
  end

  seg_decoder u_dec (
    .hex_i (cur_digit),
    .seg_o (cur_seg7)
  );

  // Next pin values; a blanked slot keeps its timing but drives everything dark
  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_d = {~cur_dp, cur_seg7};
    if ((bus.adj && blink_phase_q && cur_mask) || cur_lz) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end
  end

  // State and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - directed bench for seg_display_scan (4 digits, REFRESH_DIV=4, BLINK_DIV=16)
module tb_seg_display_scan;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] seg_tab [16];

  seg_display_scan_if #(.NUM_DIGITS(4)) dif ();

  seg_display_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic lz_expect(input int slot);
    logic z;
    z = 1'b0;
`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
    if (slot > 0) begin
      z = ~dif.dp_en[slot];
      for (int j = slot; j < 4; j++) begin
        if (dif.digits[4*j +: 4] != 4'h0) z = 1'b0;
      end
    end
`endif
    return z;
  endfunction

  task automatic check_slot(input string tag, input int slot, input logic blink_blank);
    logic [3:0] d;
    logic [3:0] ea;
    logic [7:0] es;
    logic [3:0] one;
    one = 4'b0001;
    d   = dif.digits[4*slot +: 4];
    if (blink_blank || lz_expect(slot)) begin
      ea = 4'hF;
      es = 8'hFF;
    end else begin
      ea = ~(one << slot);
      es = {~dif.dp_en[slot], seg_tab[d][6:0]};
    end
    check({tag, "_an"}, 32'(dif.an), 32'(ea));
    check({tag, "_seg"}, 32'(dif.seg), 32'(es));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    rst            = 1'b1;
    dif.digits     = 16'h1023;
    dif.dp_en      = 4'b0000;
    dif.adj        = 1'b0;
    dif.blink_mask = 4'b0000;

    // Reset held three cycles
    tick(); tick(); tick();
    check("rst_an", 32'(dif.an), 32'h0000000F);
    check("rst_seg", 32'(dif.seg), 32'h000000FF);

    // Plain scan, includes wrap back to slot 0
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_slot("scan", (k / 4) % 4, 1'b0);
    end

    // Hex letters and decimal point
    dif.digits = 16'h00AF;
    dif.dp_en  = 4'b0001;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      check_slot("dp_hex", (k / 4) % 4, 1'b0);
    end
    check("dp_hex_slot1_seg", 32'(dif.seg), 32'h00000088);

    // Blink: visible, blanked on slots 0/1, visible again
    dif.digits     = 16'h1023;
    dif.dp_en      = 4'b0000;
    dif.adj        = 1'b1;
    dif.blink_mask = 4'b0011;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      tick();
      check_slot("blink", (k / 4) % 4, ((k / 16) % 2 == 1) && ((k / 4) % 4 < 2));
    end

    // Into the next blank phase, then drop adj during slot 0
    tick();
    check_slot("blank_s0", 0, 1'b1);
    dif.adj = 1'b0;
    tick();
    check("adj_drop_an", 32'(dif.an), 32'h0000000E);
    check("adj_drop_seg", 32'(dif.seg), 32'h000000B0);

    // Re-enter adjust: 16 visible cycles, then blanking resumes
    dif.adj = 1'b1;
    for (int k = 50; k < 67; k++) begin
      tick();
      check_slot("readj", (k / 4) % 4, (k >= 66) && ((k / 4) % 4 < 2));
    end

    // Advance into slot 2 of the blank phase and reset there
    for (int k = 67; k < 73; k++) begin
      tick();
      check_slot("pre_rst", (k / 4) % 4, ((k / 4) % 4 < 2));
    end
    rst = 1'b1;
    tick();
    check("midrst_an", 32'(dif.an), 32'h0000000F);
    check("midrst_seg", 32'(dif.seg), 32'h000000FF);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_slot("post_rst", (k / 4) % 4, 1'b0);
    end

    // Leading zeros (suppressed only when the option is built in)
    dif.adj        = 1'b0;
    dif.blink_mask = 4'b0000;
    dif.digits     = 16'h0023;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
      check_slot("lz_0023", (k / 4) % 4, 1'b0);
    end
    dif.digits = 16'h0000;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
      check_slot("lz_0000", (k / 4) % 4, 1'b0);
    end
    dif.digits = 16'h0000;
    dif.dp_en  = 4'b0100;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
      check_slot("lz_dp", (k / 4) % 4, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised, time-multiplexed seven-segment driver for the stopwatch/clock display path; next generation of the fixed 4-digit display block.
- Runs on the single system clock with internal refresh and blink dividers; no derived clocks.
- Scans NUM_DIGITS hex digits with per-digit decimal points and a per-digit blink mask for adjust mode.
- Drives the active-low anode and segment pins directly.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 150000, clk cycles per digit slot (100 MHz / 150000 ≈ 666 Hz); must be ≥1.
- BLINK_DIV, 12500000, clk cycles per blink half-period (100 MHz → 4 Hz toggle); must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  packed hex values; digit i = digits[4i+3:4i]; digit 0 is rightmost (an[0]).
- dp_en  in  NUM_DIGITS  1 = light the decimal point of digit i.
- adj  in  1  adjust mode; enables blinking.
- blink_mask  in  NUM_DIGITS  1 = digit i blinks while adj=1.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low.
- seg  out  8  active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

Behaviour:
- Reset (rst=1 at a clk edge): an=all 1s, seg=8'hFF, scan_idx=0, refresh_cnt=0, blink_cnt=0, blink_phase=0. Reset applied mid-scan or mid-blink takes effect at that edge.
- Refresh counter: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and scan_idx advances; NUM_DIGITS-1 wraps to 0. Each digit is held exactly REFRESH_DIV cycles.
- scan_idx width is max(1, clog2(NUM_DIGITS)). NUM_DIGITS=1 keeps scan_idx at 0.
- Outputs are registered, updated every cycle from the current scan_idx and inputs:
  - an = ~(1 << scan_idx);
  - seg[6:0] = decode(digit[scan_idx]);
  - seg[7] = ~dp_en[scan_idx].
- Latency: an input change is visible one cycle later, while that digit is scanned.
- Decode: 0-9 standard; 10-15 give A,b,C,d,E,F.
- Blink counter:
  - Runs only while adj=1, counting 0..BLINK_DIV-1.
  - At terminal count it wraps and toggles blink_phase.
  - While adj=0, blink_cnt and blink_phase are held at 0, so entering adjust mode always starts visible.
- Blanking: when adj=1, blink_phase=1 and blink_mask[scan_idx]=1, the registered an=all 1s and seg=8'hFF for that slot. The slot timing is unchanged.
- Counters are independent. A refresh terminal and a blink terminal in the same cycle are both applied.
- adj falling during a blanked slot: digit is visible on the next cycle.
- blink_mask changes take effect on the next cycle.

Optional Feature:
- Macro SEG_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: a digit i>0 whose value and all higher-digit values are 0 is blanked (an bit high, seg=8'hFF), unless its dp_en bit is set. Digit 0 is never blanked by this rule; all-zero input shows a single "0".
- Undefined: all digits are always shown, subject only to blinking.

Decomposition:
- Package seg_display_pkg:
  - active-low segment-pattern constants for 0-F;
  - SEG_BLANK = 8'hFF;
  - function hex_to_seg(4-bit) returning 7 bits.
- Sub-module seg_decoder: combinational 4-bit to 7-segment, instantiated once on the muxed digit.
- Counters, scan, blink and output registers live in seg_display_scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16):
- Reset: hold rst 3 cycles → an=4'b1111, seg=8'hFF. First edge after release → an=4'b1110.
- Scan: digits=16'h1023, dp_en=0 → an sequence 1110,1101,1011,0111, each held 4 cycles, with seg B0,A4,C0,F9. Then wraps to 1110/B0.
- Decimal point and hex: digits=16'h00AF, dp_en=4'b0001 → slot 0 seg=8'h0E, slot 1 seg=8'h88.
- Blink: adj=1, blink_mask=4'b0011 → first 16 cycles all visible. Next 16 cycles: slots 0,1 give an=1111, seg=FF; slots 2,3 are normal. Then visible again.
- adj drop: deassert adj during a blanked slot 0 → next cycle an=1110, seg=B0. Re-assert adj → visible for 16 cycles.
- Reset mid-operation: rst during slot 2 of a blank phase → an=1111, seg=FF. After release, restarts at slot 0, visible.
- With SEG_DISPLAY_LEADING_ZERO_BLANK_EN:
  - digits=16'h0023 → slots 3,2 blanked, slots 0,1 show B0,A4.
  - digits=16'h0000 → only slot 0 shows C0.
